// File: rtl/vga_pkg.sv
// Shared VGA 640x480@60 timing constants and the coordinate type used by the
// raster generator and the character renderer.
package vga_pkg;

  typedef logic [9:0] coord_t;

  localparam int unsigned H_VISIBLE = 640;
  localparam int unsigned H_FRONT   = 16;
  localparam int unsigned H_SYNC    = 96;
  localparam int unsigned H_BACK    = 48;
  localparam int unsigned V_VISIBLE = 480;
  localparam int unsigned V_FRONT   = 10;
  localparam int unsigned V_SYNC    = 2;
  localparam int unsigned V_BACK    = 33;

  localparam int unsigned H_TOTAL      = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL      = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned H_SYNC_START = H_VISIBLE + H_FRONT;
  localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC - 1;
  localparam int unsigned V_SYNC_START = V_VISIBLE + V_FRONT;
  localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC - 1;

  // Inclusive range test used for the sync windows.
  function automatic logic in_span(input coord_t v, input coord_t lo, input coord_t hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/vga_timing_gen_pixel_tick_div.sv
// Divide-by-2 pixel enable: tick reads 0,1,0,1... from reset, so the raster
// advances on every second clk edge.
module pixel_tick_div (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  logic phase;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) phase <= 1'b0;
    else     phase <= ~phase;
  end

  assign tick = phase;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel counters, active-low syncs, visible flag
// and frame-start strobe. Define VGA_CLKDIV_EN to derive the pixel enable by
// dividing clk by 2; otherwise clk is taken to be the pixel clock.
module vga_timing_gen #(
  parameter int unsigned H_VISIBLE = vga_pkg::H_VISIBLE,
  parameter int unsigned H_FRONT   = vga_pkg::H_FRONT,
  parameter int unsigned H_SYNC    = vga_pkg::H_SYNC,
  parameter int unsigned H_BACK    = vga_pkg::H_BACK,
  parameter int unsigned V_VISIBLE = vga_pkg::V_VISIBLE,
  parameter int unsigned V_FRONT   = vga_pkg::V_FRONT,
  parameter int unsigned V_SYNC    = vga_pkg::V_SYNC,
  parameter int unsigned V_BACK    = vga_pkg::V_BACK
) (
  input  logic       clk,
  input  logic       botonRST,
  output logic [9:0] counterX,
  output logic [9:0] counterY,
  output logic       hsync,
  output logic       vsync,
  output logic       videoOn,
  output logic       pixelTick,
  output logic       frameStart
);

  import vga_pkg::*;

  localparam coord_t H_LAST   = coord_t'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
  localparam coord_t V_LAST   = coord_t'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
  localparam coord_t H_VIS_C  = coord_t'(H_VISIBLE);
  localparam coord_t V_VIS_C  = coord_t'(V_VISIBLE);
  localparam coord_t HS_FIRST = coord_t'(H_VISIBLE + H_FRONT);
  localparam coord_t HS_LAST  = coord_t'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam coord_t VS_FIRST = coord_t'(V_VISIBLE + V_FRONT);
  localparam coord_t VS_LAST  = coord_t'(V_VISIBLE + V_FRONT + V_SYNC - 1);

  coord_t x_next, y_next;
  logic   x_wrap, y_wrap;

`ifdef VGA_CLKDIV_EN
  pixel_tick_div u_tick_div (
    .clk  (clk),
    .rst  (botonRST),
    .tick (pixelTick)
  );
`else
  assign pixelTick = 1'b1;
`endif

  always_comb begin
    x_wrap = (counterX == H_LAST);
    y_wrap = (counterY == V_LAST);
    x_next = x_wrap ? '0 : counterX + 10'd1;
    y_next = counterY;
    if (x_wrap) y_next = y_wrap ? '0 : counterY + 10'd1;
  end

  // Flags are decoded from the next position so they change on the same edge
  // as the counters they describe.
  always_ff @(posedge clk or posedge botonRST) begin
    if (botonRST) begin
      counterX   <= '0;
      counterY   <= '0;
      hsync      <= 1'b1;
      vsync      <= 1'b1;
      videoOn    <= 1'b1;
      frameStart <= 1'b0;
    end else if (pixelTick) begin
      counterX   <= x_next;
      counterY   <= y_next;
      hsync      <= ~in_span(x_next, HS_FIRST, HS_LAST);
      vsync      <= ~in_span(y_next, VS_FIRST, VS_LAST);
      videoOn    <= (x_next < H_VIS_C) && (y_next < V_VIS_C);
      frameStart <= x_wrap && y_wrap;
    end
  end

endmodule
